// File: rtl/change_capture_fifo_pkg.sv
// Shared parameters and helpers for the latch-stage change capture path.
package latch_stage_pkg;

    localparam int N_DEFAULT     = 4;
    localparam int DEPTH_DEFAULT = 4;
    localparam int DROP_W        = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/change_capture_fifo_if.sv
// Valid/ready output port carrying captured values to the consumer.
interface change_capture_fifo_if
    import latch_stage_pkg::*;
#(
    parameter int N = N_DEFAULT
);

    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/change_capture_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy counter; a push into a full FIFO is
// accepted only when a pop frees a slot on the same edge.
module sync_fifo
    import latch_stage_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [N-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [N-1:0]           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [ptr_w(DEPTH):0]  count
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointers are exactly PW bits wide so they wrap mod DEPTH on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/change_capture_fifo.sv
// Detects every change of the upstream latch value and queues it; changes
// that find the queue full are counted as drops with a sticky overflow flag.
module change_capture_fifo
    import latch_stage_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           in_q,
    input  logic                   clear_ovf,
    change_capture_fifo_if.master  out_port,
    output logic [ptr_w(DEPTH):0]  count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [N-1:0] prev_q;
    logic         change;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    logic         drop;

    assign change             = (in_q != prev_q);
    assign out_port.out_valid = !fifo_empty;
    assign pop                = out_port.out_ready && !fifo_empty;
    assign drop               = change && fifo_full && !pop;

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (change),
        .wr_data (in_q),
        .rd_en   (out_port.out_ready),
        .rd_data (out_port.out_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // A drop on the same edge as clear_ovf restarts the tally at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            prev_q <= in_q;
            if (drop) begin
                overflow <= 1'b1;
                if (clear_ovf) begin
                    drop_cnt <= DROP_W'(1);
                end else if (drop_cnt != DROP_MAX) begin
                    drop_cnt <= drop_cnt + DROP_W'(1);
                end
            end else if (clear_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_change_capture_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with literal expected values.
module tb_change_capture_fifo;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] inQ;
    logic         clearOvf;
    logic [2:0]   count;
    logic         overflow;
    logic [7:0]   dropCnt;

    int checks = 0;
    int errors = 0;

    change_capture_fifo_if #(.N(N)) outIf ();

    change_capture_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_q      (inQ),
        .clear_ovf (clearOvf),
        .out_port  (outIf),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (dropCnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a queue of pending values plus drop bookkeeping.
    logic [N-1:0] mq[$];
    logic [N-1:0] mPrev = '0;
    bit           mOvf  = 1'b0;
    int           mDrop = 0;

    always @(posedge clk or posedge reset) begin
        bit chg, doPop, isFull;
        if (reset) begin
            mq.delete();
            mPrev = '0;
            mOvf  = 1'b0;
            mDrop = 0;
        end else begin
            chg    = (inQ != mPrev);
            doPop  = outIf.out_ready && (mq.size() > 0);
            isFull = (mq.size() == DEPTH);
            if (doPop) void'(mq.pop_front());
            if (clearOvf) begin
                mOvf  = 1'b0;
                mDrop = 0;
            end
            if (chg) begin
                if (!isFull || doPop) begin
                    mq.push_back(inQ);
                end else begin
                    mOvf = 1'b1;
                    if (mDrop < 255) mDrop++;
                end
            end
            mPrev = inQ;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("mdl_valid", int'(outIf.out_valid), int'(mq.size() != 0));
        checkOutput("mdl_count", int'(count), mq.size());
        checkOutput("mdl_overflow", int'(overflow), int'(mOvf));
        checkOutput("mdl_drop_cnt", int'(dropCnt), mDrop);
        if (mq.size() != 0) begin
            checkOutput("mdl_data", int'(outIf.out_data), int'(mq[0]));
        end
    end

    task automatic applyStimulus(input logic [N-1:0] q, input logic ready, input logic clr);
        inQ             = q;
        outIf.out_ready = ready;
        clearOvf        = clr;
        @(negedge clk);
    endtask

    initial begin
        reset           = 1'b1;
        inQ             = '0;
        clearOvf        = 1'b0;
        outIf.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset and idle");
        checkOutput("rst_valid", int'(outIf.out_valid), 0);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_data", int'(outIf.out_data), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_drop_cnt", int'(dropCnt), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus(4'd0, 1'b0, 1'b0);
        checkOutput("idle_valid", int'(outIf.out_valid), 0);
        checkOutput("idle_count", int'(count), 0);

        $display("[TB] single capture");
        applyStimulus(4'd1, 1'b0, 1'b0);
        checkOutput("cap_valid", int'(outIf.out_valid), 1);
        checkOutput("cap_data", int'(outIf.out_data), 1);
        checkOutput("cap_count", int'(count), 1);
        for (int i = 0; i < 5; i++) applyStimulus(4'd1, 1'b0, 1'b0);
        checkOutput("hold_count", int'(count), 1);

        $display("[TB] ordered drain");
        applyStimulus(4'd1, 1'b0, 1'b0);
        applyStimulus(4'd2, 1'b0, 1'b0);
        applyStimulus(4'd3, 1'b0, 1'b0);
        checkOutput("drain_count", int'(count), 3);
        checkOutput("drain_head1", int'(outIf.out_data), 1);
        applyStimulus(4'd3, 1'b1, 1'b0);
        checkOutput("drain_head2", int'(outIf.out_data), 2);
        applyStimulus(4'd3, 1'b1, 1'b0);
        checkOutput("drain_head3", int'(outIf.out_data), 3);
        applyStimulus(4'd3, 1'b1, 1'b0);
        checkOutput("drain_valid", int'(outIf.out_valid), 0);

        $display("[TB] overflow");
        for (int v = 1; v <= 6; v++) applyStimulus(4'(v), 1'b0, 1'b0);
        checkOutput("ovf_count", int'(count), 4);
        checkOutput("ovf_head", int'(outIf.out_data), 1);
        checkOutput("ovf_flag", int'(overflow), 1);
        checkOutput("ovf_drops", int'(dropCnt), 2);
        applyStimulus(4'd6, 1'b0, 1'b1);
        checkOutput("clr_flag", int'(overflow), 0);
        checkOutput("clr_drops", int'(dropCnt), 0);
        checkOutput("clr_count", int'(count), 4);
        applyStimulus(4'd7, 1'b0, 1'b1);
        checkOutput("clrdrop_flag", int'(overflow), 1);
        checkOutput("clrdrop_drops", int'(dropCnt), 1);
        applyStimulus(4'd7, 1'b0, 1'b1);
        checkOutput("clr2_flag", int'(overflow), 0);

        $display("[TB] full with push and pop");
        applyStimulus(4'd9, 1'b1, 1'b0);
        checkOutput("fpp_count", int'(count), 4);
        checkOutput("fpp_head", int'(outIf.out_data), 2);
        checkOutput("fpp_flag", int'(overflow), 0);
        applyStimulus(4'd9, 1'b1, 1'b0);
        checkOutput("fpp_next3", int'(outIf.out_data), 3);
        applyStimulus(4'd9, 1'b1, 1'b0);
        checkOutput("fpp_next4", int'(outIf.out_data), 4);
        applyStimulus(4'd9, 1'b1, 1'b0);
        checkOutput("fpp_tail", int'(outIf.out_data), 9);
        checkOutput("fpp_tail_count", int'(count), 1);
        applyStimulus(4'd9, 1'b1, 1'b0);
        checkOutput("fpp_empty", int'(outIf.out_valid), 0);

        $display("[TB] reset mid-stream");
        applyStimulus(4'd1, 1'b0, 1'b0);
        applyStimulus(4'd2, 1'b0, 1'b0);
        applyStimulus(4'd3, 1'b0, 1'b0);
        checkOutput("mid_pre_count", int'(count), 3);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_async_valid", int'(outIf.out_valid), 0);
        checkOutput("mid_async_count", int'(count), 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'd5, 1'b0, 1'b0);
        checkOutput("mid_post_count", int'(count), 1);
        checkOutput("mid_post_data", int'(outIf.out_data), 5);
        applyStimulus(4'd5, 1'b0, 1'b0);
        checkOutput("mid_hold_count", int'(count), 1);

        $display("[TB] empty with push and pop");
        applyStimulus(4'd5, 1'b1, 1'b0);
        applyStimulus(4'd6, 1'b1, 1'b0);
        checkOutput("epp_count", int'(count), 1);
        checkOutput("epp_data", int'(outIf.out_data), 6);
        applyStimulus(4'd6, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_capture_fifo.md
# change_capture_fifo

Downstream consumer of the `d_latch` stage. It watches the latch's N-bit `out_q` value and detects every change of that value. Each new value is pushed into a small synchronous FIFO. The queued values are presented on a valid/ready output port. Values that arrive while the FIFO is full are counted as drops, and a sticky overflow flag records them.

## Interface
- `N`, 4, data width; matches the `d_latch` width.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_q` input N: value from `d_latch.out_q`.
- `clear_ovf` input 1: synchronous clear of `overflow` and `drop_cnt`.
- `out_data` output N: FIFO head value.
- `out_valid` output 1: FIFO not empty.
- `out_ready` input 1: consumer accepts the head.
- `count` output $clog2(DEPTH)+1: current occupancy.
- `overflow` output 1: sticky; set when a change is dropped.
- `drop_cnt` output 8: number of dropped changes; saturates at 255.

## Operation
- `prev_q` register holds the last sampled `in_q`. Reset value is 0.
- `change = (in_q != prev_q)`, evaluated combinationally. `prev_q <= in_q` on every edge.
- Push happens on an edge where `change` is 1. The written data is the current `in_q`.
- Pop happens on an edge where `out_valid && out_ready`.
- Full, push, no pop: the push is dropped. `overflow <= 1`, and `drop_cnt` increments unless already at 255. FIFO contents are unchanged.
- Full, push and pop on the same edge: both succeed. `count` stays at DEPTH and the write pointer advances.
- Empty, push and pop on the same edge: there is no pop because `out_valid` is 0. The push succeeds, `count` becomes 1.
- `clear_ovf` and a drop on the same edge: the drop wins. `overflow` becomes 1 and `drop_cnt` becomes 1.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally mod DEPTH.
  - `count` = writes − pops, range 0..DEPTH.
  - Full is `count == DEPTH`; empty is `count == 0`.
- `out_data` comes straight from the storage array at the read pointer. It must be stable while `out_valid && !out_ready`.
- Reset values:
  - `prev_q` = 0, pointers = 0, `count` = 0.
  - `out_valid` = 0, `overflow` = 0, `drop_cnt` = 0.
  - `out_data` = 0; storage is cleared on reset.
- Reset asserted mid-operation empties the FIFO immediately, asynchronously. On the first edge after release, any `in_q != 0` is captured as a change.

## Timing
- Capture latency is 1 cycle. A change presented before edge k makes `out_valid` go to 1 after edge k, with `out_data = in_q`.
- A value held for several cycles produces exactly one push.
- A value that toggles A→B→A over three edges produces pushes B, A.
- Throughput is one push and one pop per cycle. There are no combinational paths from `out_ready` to any output except through registers.
- `count`, `out_valid` and `overflow` all update on the same edge as the push or pop that causes them.

## Structure
- Package `latch_stage_pkg` holds:
  - default `N` and `DEPTH` localparams;
  - `DROP_W = 8`;
  - the function `ptr_w(depth) = $clog2(depth)`.
- Sub-module `sync_fifo #(N, DEPTH)`:
  - ports: `clk`, `reset`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, `count`.
- Top level contains only `prev_q`, the change compare, and the overflow/drop logic.

## Test plan
- **Reset/idle:** assert `reset` with `in_q` = 0. Expect all outputs at 0. Release reset with `in_q` held at 0 for 10 cycles: `out_valid` stays 0 and `count` stays 0.
- **Single capture:** `in_q` goes 0→1, `out_ready` = 0.
  - After 1 edge: `out_valid` = 1, `out_data` = 1, `count` = 1.
  - Hold `in_q` = 1 for 5 edges: `count` stays 1.
- **Ordered drain:** drive `in_q` 1,2,3 on consecutive edges with `out_ready` = 0; `count` = 3. Then raise `out_ready`: `out_data` reads 1, 2, 3 on successive cycles, and `out_valid` falls after the third pop.
- **Overflow:** `DEPTH` = 4, `out_ready` = 0, drive `in_q` 1..6. Expect:
  - `count` = 4, FIFO holds 1,2,3,4;
  - `overflow` = 1, `drop_cnt` = 2.
  - Then pulse `clear_ovf`: `overflow` = 0 and `drop_cnt` = 0; FIFO is unchanged.
- **Full with simultaneous push/pop:** FIFO full with 1..4, `out_ready` = 1, `in_q` goes 4→9. After the edge:
  - `count` = 4, head = 2, tail = 9;
  - `overflow` = 0.
- **Reset mid-stream:** with `count` = 3, assert `reset` asynchronously between edges. `out_valid` and `count` go to 0 before the next edge. After release with `in_q` = 5, one entry of 5 is captured.
